ram_master: RTL
===============

RAM_MASTER -- requirements
Module: ram_master

Interface
REQ-001 Parameters, one per line:
  ADDR_W, 12, RAM address width.
  DATA_W, 4, RAM data width.
  WAIT_CYC, 1, extra read wait cycles (0..7).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset; asynchronous, active-low.
REQ-004 req_valid  in  1  request offered.
REQ-005 req_ready  out  1  master idle and able to accept a request.
REQ-006 req_we  in  1  1 = write, 0 = read.
REQ-007 req_addr  in  ADDR_W  target address.
REQ-008 req_wdata  in  DATA_W  write data.
REQ-009 rsp_valid  out  1  one-cycle completion pulse, for reads and writes.
REQ-010 rsp_rdata  out  DATA_W  read data, valid while rsp_valid=1 after a read.
REQ-011 cs  out  1  RAM chip select, active-high.
REQ-012 we  out  1  RAM write enable, active-high.
REQ-013 dir  out  ADDR_W  RAM address.
REQ-014 data  inout  DATA_W  shared tri-state RAM data bus.

Function
REQ-015 A request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1; req_we, req_addr and req_wdata SHALL be latched on that edge.
REQ-016 req_ready SHALL be 1 only in IDLE; req_valid while busy SHALL be ignored and not queued.
REQ-017 FSM states SHALL be IDLE, SETUP, ACCESS, DONE.
REQ-018 Transitions: IDLE->SETUP on accept; SETUP->ACCESS always; ACCESS->DONE when the access counter expires; DONE->IDLE always.
REQ-019 SETUP: dir = latched addr, we = latched we, cs=0.
REQ-020 ACCESS, write: cs=1 for exactly 1 cycle.
REQ-021 ACCESS, read: cs=1 for WAIT_CYC+1 cycles, counted by an internal down-counter loaded on the SETUP->ACCESS transition.
REQ-022 DONE: cs=0; dir and we held; rsp_valid=1 for exactly that cycle.
REQ-023 Read data SHALL be sampled from data on the rising edge that ends the last ACCESS cycle and presented on rsp_rdata in DONE.
REQ-024 rsp_rdata SHALL hold its last read value through writes and idle cycles.
REQ-025 Latency from the accept edge to the rsp_valid cycle SHALL be 3 cycles for writes and 3+WAIT_CYC cycles for reads.
REQ-026 A new request SHALL be accepted no earlier than the cycle after DONE (back-to-back throughput: 4 cycles per write, 4+WAIT_CYC per read).
REQ-027 Bus ownership: the master SHALL drive data with latched wdata only in SETUP, ACCESS and DONE of a write; all other cycles SHALL be high-Z.
REQ-028 The master SHALL never drive data while cs=1 and we=0.
REQ-029 Read-to-write and write-to-read turnaround is provided by SETUP (cs=0); no additional idle cycle SHALL be inserted.
REQ-030 All outputs except data SHALL be registered; no combinational path from req_* to cs, we or dir.

Reset
REQ-031 While rst_n=0: state=IDLE, cs=0, we=0, dir=0, rsp_valid=0, rsp_rdata=0, req_ready=1, counter=0, data high-Z.
REQ-032 rst_n asserted mid-transaction SHALL abort immediately (asynchronously), with no rsp_valid for the aborted request.
REQ-033 After rst_n rises, the first request SHALL be accepted on the first rising edge where req_valid=1.

Verification
REQ-034 Write 0x5A3<-0xC -> SETUP at cycle+1 with dir=0x5A3, we=1; cs=1 exactly at cycle+2; data=0xC from cycle+1 to cycle+3; rsp_valid at cycle+3.
REQ-035 Read 0x5A3 with a behavioural RAM model returning 0xC, WAIT_CYC=1 -> cs=1 for 2 cycles with we=0; data not driven by the master; rsp_valid at cycle+4 with rsp_rdata=0xC.
REQ-036 Back-to-back write 0x000<-0x3, read 0x000, write 0xFFF<-0xF with req_valid held high -> accepts 4 cycles apart, then 5; no cycle where both drivers are active; read returns 0x3.
REQ-037 req_valid pulsed during ACCESS -> ignored; exactly one rsp_valid pulse.
REQ-038 rst_n=0 during a read ACCESS -> cs=0 and data high-Z in the same cycle, no rsp_valid; a following write 0x001<-0x7 completes normally.
REQ-039 WAIT_CYC=0 read -> cs=1 for 1 cycle; rsp_valid at cycle+3.

Source files
------------

// File: rtl/ram_master.sv
// Single-port RAM bus master: one request at a time, sequenced IDLE -> SETUP -> ACCESS -> DONE.
// Drives the shared tri-state data bus only while a write is in flight.
module ram_master #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 4,
    parameter int WAIT_CYC = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              cs,
    output logic              we,
    output logic [ADDR_W-1:0] dir,
    inout  wire  [DATA_W-1:0] data
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [2:0] WAIT_LD = 3'(WAIT_CYC);

    logic [1:0]        state_q,  state_d;
    logic [2:0]        cnt_q,    cnt_d;
    logic              we_q,     we_d;
    logic [ADDR_W-1:0] dir_q,    dir_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;
    logic              drive_q,  drive_d;
    logic [DATA_W-1:0] rdata_q,  rdata_d;
    logic              cs_q,     cs_d;
    logic              rsp_q,    rsp_d;
    logic              ready_q,  ready_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        dir_d   = dir_q;
        wdata_d = wdata_q;
        drive_d = drive_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d = S_SETUP;
                    we_d    = req_we;
                    dir_d   = req_addr;
                    wdata_d = req_wdata;
                    drive_d = req_we;
                end
            end
            S_SETUP: begin
                state_d = S_ACCESS;
                cnt_d   = we_q ? '0 : WAIT_LD;
            end
            S_ACCESS: begin
                // Bus is sampled on the edge that closes the final ACCESS cycle.
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    if (!we_q) begin
                        rdata_d = data;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                drive_d = 1'b0;
            end
        endcase
        // Registered outputs are decoded from the next state so they line up with it.
        cs_d    = (state_d == S_ACCESS);
        rsp_d   = (state_d == S_DONE);
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            dir_q   <= '0;
            wdata_q <= '0;
            drive_q <= 1'b0;
            rdata_q <= '0;
            cs_q    <= 1'b0;
            rsp_q   <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            dir_q   <= dir_d;
            wdata_q <= wdata_d;
            drive_q <= drive_d;
            rdata_q <= rdata_d;
            cs_q    <= cs_d;
            rsp_q   <= rsp_d;
            ready_q <= ready_d;
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_q;
    assign rsp_rdata = rdata_q;
    assign cs        = cs_q;
    assign we        = we_q;
    assign dir       = dir_q;
    assign data      = drive_q ? wdata_q : 'z;

endmodule
